// File: rtl/weight_load_sched.sv
// Streams the N x N coupling-weight matrix into the neuron weight registers row-major,
// filling the diagonal with zero, then pulses load once to start the run sequence.
module weight_load_sched #(
  parameter int N  = 15,
  parameter int WW = 5,
  parameter int IW = 4
) (
  input  logic                 sclk,
  input  logic                 re_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 w_valid,
  input  logic signed [WW-1:0] w_data,
  output logic                 w_ready,
  output logic                 wr_en,
  output logic [IW-1:0]        wr_row,
  output logic [IW-1:0]        wr_col,
  output logic signed [WW-1:0] wr_data,
  output logic                 busy,
  output logic                 load
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, PULSE} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] row;
  logic [IW-1:0] col;
  logic          diag;
  logic          step;

  assign diag = (row == col);
  // A cell is written when it is diagonal (no word needed) or a word is handed over.
  assign step = (state == LOAD) && (diag || w_valid);

  assign w_ready = (state == LOAD) && !diag;
  assign busy    = (state != IDLE);
  assign load    = (state == PULSE);

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (step) begin
        wr_en   <= 1'b1;
        wr_row  <= row;
        wr_col  <= col;
        wr_data <= diag ? '0 : w_data;
      end
      case (state)
        IDLE: begin
          if (!abort && start) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
          end
        end
        LOAD: begin
          // The word accepted in the abort cycle is still written; only the walk stops.
          if (abort) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
          end else if (step) begin
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                row   <= '0;
                state <= FLUSH;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: state <= PULSE;
        PULSE: state <= IDLE;
        default: begin
          state <= IDLE;
          row   <= '0;
          col   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed/randomised bench for weight_load_sched: a cell-index model predicts the write
// list, handshake totals, stall count and load-pulse timing of each matrix load.
module tb_weight_load_sched;
  localparam int N = 15, WW = 5, IW = 4;
  localparam int CELLS = N * N;
  localparam int WORDS = N * (N - 1);

  logic                 sclk = 1'b0;
  logic                 re_n = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 w_valid = 1'b0;
  logic signed [WW-1:0] w_data = '0;
  logic                 w_ready, wr_en, busy, load;
  logic [IW-1:0]        wr_row, wr_col;
  logic signed [WW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  weight_load_sched #(.N(N), .WW(WW), .IW(IW)) dut (
    .sclk(sclk), .re_n(re_n), .start(start), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .load(load)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({w_ready, wr_en, wr_row, wr_col, wr_data, busy, load});
  endfunction

  // vmode: 0 valid always, 1 alternating, 2 random. dmode: 0 k mod 16, 1 random data.
  task automatic run_load(input int vmode, input int dmode, input bit noise,
                          input int abort_hs, input int reset_wr, input string name);
    logic signed [WW-1:0] words[$];
    logic [2*IW+WW-1:0]   exp_w[$];
    logic [2*IW+WW-1:0]   obs_w[$];
    logic signed [WW-1:0] wv;
    int widx, hs, mk, stalls, cyc, load_cnt, load_cyc, first_wr, last_wr;
    int busy_cnt, idle_cyc, abort_cyc, n0;
    bit done, v, exp_ready, was_reset;

    for (int j = 0; j < WORDS; j++) begin
      wv = (dmode == 0) ? WW'(j % 16) : WW'($urandom_range(0, 31));
      words.push_back(wv);
    end
    widx = 0;
    for (int k = 0; k < CELLS; k++) begin
      if (k / N == k % N) exp_w.push_back({IW'(k / N), IW'(k % N), WW'(0)});
      else begin
        exp_w.push_back({IW'(k / N), IW'(k % N), words[widx]});
        widx++;
      end
    end

    widx = 0; hs = 0; mk = 0; stalls = 0; load_cnt = 0; load_cyc = -1;
    first_wr = -1; last_wr = -1; busy_cnt = 0; idle_cyc = -1; abort_cyc = -1;
    n0 = 0; done = 0; was_reset = 0;

    @(negedge sclk);
    start = 1'b1; abort = 1'b0; w_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 1500) begin
      @(negedge sclk);
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (wr_en) begin
        obs_w.push_back({wr_row, wr_col, wr_data});
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (load) begin load_cnt++; load_cyc = cyc; end
      if (busy) busy_cnt++;

      if (reset_wr >= 0 && obs_w.size() == reset_wr) begin
        w_valid = 1'b0;
        #2 re_n = 1'b0;
        #1 check({name, "_reset_outs"}, all_outs(), 32'd0);
        repeat (3) @(negedge sclk);
        re_n = 1'b1;
        @(negedge sclk);
        check({name, "_reset_busy"}, 32'(busy), 32'd0);
        repeat (3) begin
          @(negedge sclk);
          if (load) load_cnt++;
        end
        check({name, "_reset_noload"}, 32'(load_cnt), 32'd0);
        was_reset = 1; done = 1;
      end else if (abort_cyc >= 0) begin
        w_valid = 1'b0;
        if (cyc == abort_cyc + 1) check({name, "_abort_busy"}, 32'(busy), 32'd0);
        if (cyc == abort_cyc + 4) done = 1;
      end else if (cyc > 1 && !busy) begin
        idle_cyc = cyc; done = 1;
      end else begin
        case (vmode)
          0: v = 1'b1;
          1: v = cyc[0];
          default: v = 1'($urandom_range(0, 1));
        endcase
        w_valid = v;
        w_data = (widx < WORDS) ? words[widx] : WW'($urandom_range(0, 31));
        if (noise && busy) start = ($urandom_range(0, 3) == 0);
        if (abort_hs >= 0 && hs == abort_hs) begin
          abort = 1'b1; abort_cyc = cyc; n0 = obs_w.size();
        end
        exp_ready = (mk < CELLS) && (mk / N != mk % N);
        check({name, "_w_ready"}, 32'(w_ready), 32'(exp_ready));
        if (v && w_ready) begin hs++; widx++; end
        if (mk < CELLS) begin
          if (mk / N == mk % N || v) mk++;
          else stalls++;
        end
      end
    end

    for (int i = 0; i < obs_w.size() && i < CELLS; i++)
      check($sformatf("%s_write%0d", name, i), 32'(obs_w[i]), 32'(exp_w[i]));

    if (abort_hs >= 0) begin
      check({name, "_abort_seen"}, 32'(abort_cyc >= 0), 32'd1);
      check({name, "_abort_trailing_le1"}, 32'(obs_w.size() - n0 <= 1), 32'd1);
      check({name, "_abort_noload"}, 32'(load_cnt), 32'd0);
    end else if (!was_reset) begin
      check({name, "_writes"}, 32'(obs_w.size()), 32'(CELLS));
      check({name, "_handshakes"}, 32'(hs), 32'(WORDS));
      check({name, "_load_count"}, 32'(load_cnt), 32'd1);
      check({name, "_load_cycle"}, 32'(load_cyc), 32'(227 + stalls));
      check({name, "_first_write"}, 32'(first_wr), 32'd2);
      check({name, "_last_write"}, 32'(last_wr), 32'(226 + stalls));
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(227 + stalls));
      check({name, "_idle_cycle"}, 32'(idle_cyc), 32'(228 + stalls));
    end
    if (vmode == 1 && abort_hs < 0 && reset_wr < 0)
      check({name, "_stalls_seen"}, 32'(stalls > 0), 32'd1);
  endtask

  initial begin
    re_n = 1'b0;
    #3 check("reset_outs_async", all_outs(), 32'd0);
    repeat (3) @(negedge sclk);
    check("reset_outs_held", all_outs(), 32'd0);
    re_n = 1'b1;
    @(negedge sclk);
    check("reset_release_busy", 32'(busy), 32'd0);

    run_load(0, 0, 1'b0, -1, -1, "full");
    run_load(1, 1, 1'b0, -1, -1, "backpressure");
    run_load(2, 1, 1'b1, -1, -1, "start_noise");

    @(negedge sclk);
    start = 1'b1; abort = 1'b1;
    @(negedge sclk);
    start = 1'b0; abort = 1'b0;
    check("prio_abort_busy", 32'(busy), 32'd0);
    @(negedge sclk);
    check("prio_not_queued", 32'(busy), 32'd0);

    run_load(2, 1, 1'b0, 100, -1, "abort");
    run_load(0, 1, 1'b0, -1, -1, "after_abort");
    run_load(2, 1, 1'b0, -1, 150, "reset_mid");
    run_load(0, 1, 1'b0, -1, -1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
